// File: rtl/mer_pkg.sv
// mer_pkg: FSM states, symbol LFSR constants and 1s17 4-ASK levels for the MER window generator
package mer_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_RUN, ST_FLUSH} state_t;

    localparam logic [19:0] LFSR_SEED = 20'h00001;
    localparam logic [19:0] LFSR_TAPS = 20'h00009;

    localparam logic [17:0] LVL_N075 = 18'h28000;
    localparam logic [17:0] LVL_N025 = 18'h38000;
    localparam logic [17:0] LVL_P025 = 18'h08000;
    localparam logic [17:0] LVL_P075 = 18'h18000;

    function automatic logic [17:0] level_of(input logic [1:0] s);
        return s == 2'b00 ? LVL_N075 : s == 2'b01 ? LVL_N025 : s == 2'b11 ? LVL_P025 : LVL_P075;
    endfunction

endpackage

// File: rtl/sym_lfsr.sv
// sym_lfsr: 20-bit Fibonacci LFSR (x^20+x^17+1) producing the test symbol stream
module sym_lfsr
    import mer_pkg::*;
(
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        adv,
    output logic [19:0] state
);

    logic [19:0] state_q, state_d;

    // shift toward bit 0; the new MSB is the parity of the tapped bits
    always_comb state_d = adv ? {^(state_q & LFSR_TAPS), state_q[19:1]} : state_q;

    // state register, reseeded on reset
    always_ff @(posedge sys_clk) state_q <= reset ? LFSR_SEED : state_d;

    assign state = state_q;

endmodule

// File: rtl/mer_window_gen.sv
// mer_window_gen: symbol-rate test pattern source with windowed measurement control for MER averaging
module mer_window_gen
    import mer_pkg::*;
#(
    parameter int LFSR_WID = 20,
    parameter int SYM_DIV  = 4
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        sym_clk_en,
    output logic [1:0]  sym_out,
    output logic [17:0] level_out,
    output logic        clr_acc,
    output logic        busy,
    output logic [15:0] win_count
);

    localparam logic [4:0]        DIV_LAST = 5'(SYM_DIV - 1);
    localparam logic [LFSR_WID:0] WIN_LEN  = {1'b1, {LFSR_WID{1'b0}}};

    state_t             state_q, state_d;
    logic [4:0]         div_q, div_d;
    logic [LFSR_WID:0]  cnt_q, cnt_d, cnt_inc;
    logic               stop_q, stop_d;
    logic               clr_q, clr_d;
    logic [15:0]        win_q, win_d;
    logic [19:0]        lfsr;
    logic               lfsr_rst;
    logic               wrap;

    assign sym_clk_en = div_q == DIV_LAST;
    assign cnt_inc    = cnt_q + 1'b1;
    assign wrap       = cnt_inc == WIN_LEN;
    // an all-zero LFSR can never leave that state, so reseed it if an upset ever lands there
    assign lfsr_rst   = reset || lfsr == '0;

    sym_lfsr u_lfsr (
        .sys_clk (sys_clk),
        .reset   (lfsr_rst),
        .adv     (sym_clk_en),
        .state   (lfsr)
    );

    // divider, window sequencing, stop latch and window counter next-state
    always_comb begin
        div_d   = sym_clk_en ? '0 : div_q + 5'd1;
        state_d = state_q;
        cnt_d   = cnt_q;
        stop_d  = 1'b0;
        clr_d   = 1'b0;
        win_d   = win_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d = ST_ALIGN;
                    win_d   = '0;
                end
            end
            ST_ALIGN: begin
                if (stop) state_d = ST_IDLE;
                else if (sym_clk_en) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                stop_d = stop_q || stop;
                if (clr_q && stop_q) begin
                    state_d = ST_FLUSH;
                    stop_d  = 1'b0;
                end
                if (sym_clk_en) begin
                    cnt_d = wrap ? '0 : cnt_inc;
                    clr_d = wrap;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clr_q && win_q != 16'hFFFF) win_d = win_q + 16'd1;
    end

    // state registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            clr_q   <= 1'b0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            stop_q  <= stop_d;
            clr_q   <= clr_d;
            win_q   <= win_d;
        end
    end

    assign sym_out   = lfsr[1:0];
    assign level_out = level_of(lfsr[1:0]);
    assign clr_acc   = clr_q;
    assign busy      = state_q == ST_ALIGN || state_q == ST_RUN;
    assign win_count = win_q;

endmodule
